// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants, buffer type and leading-zero helper for the scan controller
package seg_pkg;

  localparam int NUM_DIG = 6;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low g..a codes; entry 0 is the rightmost element of the concatenation.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef struct packed {
    logic [4*NUM_DIG-1:0] data;
    logic [NUM_DIG-1:0]   point;
    logic                 blank_en;
  } disp_buf_t;

  function automatic logic [NUM_DIG-1:0] lead_blank_mask(
    input logic [4*NUM_DIG-1:0] d,
    input logic                 en
  );
    logic [NUM_DIG-1:0] m;
    logic               run;
    m   = '0;
    run = en;
    // Digit 0 is left out of the loop so it always stays visible.
    for (int i = NUM_DIG - 1; i > 0; i--) begin
      run  = run && (d[4*i +: 4] == 4'h0);
      m[i] = run;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - valid/ready display load port
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic                 load_valid;
  logic                 load_ready;
  logic [4*NUM_DIG-1:0] data;
  logic [NUM_DIG-1:0]   point;
  logic                 blank_en;

  modport master (
    output load_valid,
    output data,
    output point,
    output blank_en,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  data,
    input  point,
    input  blank_en,
    output load_ready
  );

endinterface

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - nibble plus decimal point to active-low segment code
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {HEX_SEG[nibble][7] & ~dp, HEX_SEG[nibble][6:0]};

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - six-digit dynamic scan sequencer with frame-aligned double buffering
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_CNT = 50000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  seg_scan_ctrl_if.slave    load,
  output logic [NUM_DIG-1:0] sel,
  output logic [7:0]        seg,
  output logic              frame_done
);

  localparam int CW = $clog2(SCAN_CNT);

  logic [CW-1:0]      cnt_scan;
  logic [2:0]         idx;
  disp_buf_t          active_buf;
  disp_buf_t          pend_buf;
  logic               pend_flag;
  logic               scan_last;
  logic               boundary;
  logic               transfer;
  logic [NUM_DIG-1:0] blank_mask;
  logic [3:0]         cur_nib;
  logic               cur_dp;
  logic               cur_blank;
  logic [NUM_DIG-1:0] sel_next;
  logic [7:0]         seg_dec;
  logic [7:0]         seg_next;

  assign scan_last       = (cnt_scan == CW'(SCAN_CNT - 1));
  assign boundary        = scan_last && (idx == 3'(NUM_DIG - 1));
  assign frame_done      = boundary;
  assign load.load_ready = ~pend_flag;
  assign transfer        = load.load_valid && ~pend_flag;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_scan <= '0;
      idx      <= '0;
    end else if (scan_last) begin
      cnt_scan <= '0;
      idx      <= (idx == 3'(NUM_DIG - 1)) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt_scan <= cnt_scan + 1'b1;
    end
  end

  // Transfer and commit are exclusive: a transfer needs the pending slot empty.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pend_flag  <= 1'b0;
      pend_buf   <= '0;
      active_buf <= '0;
    end else if (transfer) begin
      pend_buf  <= '{data: load.data, point: load.point, blank_en: load.blank_en};
      pend_flag <= 1'b1;
    end else if (boundary && pend_flag) begin
      active_buf <= pend_buf;
      pend_flag  <= 1'b0;
    end
  end

  assign blank_mask = lead_blank_mask(active_buf.data, active_buf.blank_en);

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    sel_next  = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (idx == 3'(i)) begin
        cur_nib     = active_buf.data[4*i +: 4];
        cur_dp      = active_buf.point[i];
        cur_blank   = blank_mask[i];
        sel_next[i] = 1'b1;
      end
    end
  end

  seg_hex_decode u_dec (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (seg_dec)
  );

  assign seg_next = cur_blank ? SEG_BLANK : seg_dec;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel <= '0;
      seg <= SEG_BLANK;
    end else begin
      sel <= sel_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  localparam int SCAN_CNT = 64;
  localparam int BOUND    = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       frame_done;
  int         n_checks = 0;
  int         n_fail   = 0;

  seg_scan_ctrl_if ld ();

  seg_scan_ctrl #(.SCAN_CNT(SCAN_CNT)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .load       (ld),
    .sel        (sel),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_fd(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (frame_done !== 1'b1 && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_fd_seen"}, 32'(frame_done), 32'd1);
  endtask

  // Entered at the negedge just after a boundary posedge; digit 0 of the new frame appears next.
  task automatic show_frame(input string tag, input logic [5:0][7:0] exp);
    for (int d = 0; d < NUM_DIG; d++) begin
      @(negedge clk);
      check_eq($sformatf("%s_d%0d_first_sel", tag, d), 32'(sel), 32'(6'b1 << d));
      check_eq($sformatf("%s_d%0d_first_seg", tag, d), 32'(seg), 32'(exp[d]));
      repeat (SCAN_CNT - 1) @(negedge clk);
      check_eq($sformatf("%s_d%0d_last_sel", tag, d), 32'(sel), 32'(6'b1 << d));
      check_eq($sformatf("%s_d%0d_last_seg", tag, d), 32'(seg), 32'(exp[d]));
    end
  endtask

  task automatic check_frame(input string tag, input logic [5:0][7:0] exp);
    wait_fd(tag);
    @(negedge clk);
    show_frame(tag, exp);
  endtask

  task automatic do_load(input string tag, input logic [23:0] d, input logic [5:0] p, input logic b);
    int k;
    ld.load_valid = 1'b1;
    ld.data       = d;
    ld.point      = p;
    ld.blank_en   = b;
    k = 0;
    while (ld.load_ready !== 1'b1 && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_ready_seen"}, 32'(ld.load_ready), 32'd1);
    @(negedge clk);
    ld.load_valid = 1'b0;
    check_eq({tag, "_ready_low"}, 32'(ld.load_ready), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_sel"}, 32'(sel), 32'h0);
    check_eq({tag, "_seg"}, 32'(seg), 32'hFF);
    check_eq({tag, "_ready"}, 32'(ld.load_ready), 32'd1);
    check_eq({tag, "_fd"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    ld.load_valid = 1'b0;
    ld.data       = '0;
    ld.point      = '0;
    ld.blank_en   = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst_init");
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel_sel", 32'(sel), 32'h01);
    check_eq("rel_seg", 32'(seg), 32'hC0);

    repeat (100) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rel2_sel", 32'(sel), 32'h01);
    check_eq("rel2_seg", 32'(seg), 32'hC0);

    wait_fd("sync2");
    @(negedge clk);
    do_load("t2", 24'h123456, 6'b000000, 1'b0);
    check_frame("t2", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

    do_load("t3", 24'h000120, 6'b000000, 1'b1);
    check_frame("t3", {8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hC0});

    do_load("t4", 24'h888888, 6'b000100, 1'b0);
    check_frame("t4", {8'h80, 8'h80, 8'h80, 8'h00, 8'h80, 8'h80});

    do_load("t4z", 24'h000000, 6'b001001, 1'b1);
    check_frame("t4z", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h40});

    do_load("t5a", 24'hABCDEF, 6'b000000, 1'b0);
    ld.load_valid = 1'b1;
    ld.data       = 24'h987654;
    ld.point      = 6'b100000;
    ld.blank_en   = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("t5_held_ignored", 32'(ld.load_ready), 32'd0);
    k = 0;
    while (ld.load_ready !== 1'b1 && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    check_eq("t5_ready_back", 32'(ld.load_ready), 32'd1);
    fork
      show_frame("t5a", {8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E});
      begin
        @(negedge clk);
        ld.load_valid = 1'b0;
        check_eq("t5b_ready_low", 32'(ld.load_ready), 32'd0);
      end
    join
    check_frame("t5b", {8'h10, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99});

    k = 0;
    while (frame_done !== 1'b1 && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    check_eq("t5c_fd_seen", 32'(frame_done), 32'd1);
    check_eq("t5c_ready_at_fd", 32'(ld.load_ready), 32'd1);
    ld.load_valid = 1'b1;
    ld.data       = 24'h00C0DE;
    ld.point      = 6'b000000;
    ld.blank_en   = 1'b1;
    @(negedge clk);
    ld.load_valid = 1'b0;
    check_eq("t5c_ready_low", 32'(ld.load_ready), 32'd0);
    show_frame("t5c_old", {8'h10, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99});
    check_frame("t5c", {8'hFF, 8'hFF, 8'hC6, 8'hC0, 8'hA1, 8'h86});

    @(negedge clk);
    do_load("t6", 24'h111111, 6'b111111, 1'b0);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_rel_sel", 32'(sel), 32'h01);
    check_eq("t6_rel_seg", 32'(seg), 32'hC0);
    check_eq("t6_rel_ready", 32'(ld.load_ready), 32'd1);
    check_frame("t6", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
